// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch front end with a small fetch queue.
//
// The PC register drives a combinational instruction memory. In RUN, each
// returned block is pushed into a FQ_DEPTH-entry queue together with its PC,
// and the PC then advances by one block. Decode pops blocks from the queue
// head with a valid/ready handshake. A redirect in any state clears the queue,
// loads the aligned target PC and spends one FLUSH cycle before fetch resumes.
//
// Optional build macro: FETCH_BYPASS_EN. When defined and the queue is empty,
// the block being fetched is presented to decode in the same cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fetch_en        global fetch enable
//   imem_pc_addr    fetch address to instruction memory (the PC register)
//   imem_instr_blk  CORE_WIDTH instructions returned for imem_pc_addr
//   dec_valid/ready head-of-queue handshake toward decode
//   dec_instr_blk   head block instructions
//   dec_pc          PC of instruction 0 of the head block
//   redirect_valid  branch/exception redirect request
//   redirect_pc     redirect target (low two bits ignored)
//   fq_count        current queue occupancy
module fetch_controller #(
    parameter int unsigned CORE_WIDTH = 2,
    parameter int unsigned FQ_DEPTH   = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fetch_en,
    output logic [31:0]                        imem_pc_addr,
    input  logic [CORE_WIDTH*32-1:0]           imem_instr_blk,
    output logic                               dec_valid,
    input  logic                               dec_ready,
    output logic [CORE_WIDTH*32-1:0]           dec_instr_blk,
    output logic [31:0]                        dec_pc,
    input  logic                               redirect_valid,
    input  logic [31:0]                        redirect_pc,
    output logic [$clog2(FQ_DEPTH):0]          fq_count
);

    localparam int unsigned BLK_W  = CORE_WIDTH * 32;
    localparam int unsigned PTR_W  = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PC_INC = 4 * CORE_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Queue payload; contents are only meaningful between head and tail.
    logic [31:0]        pc_mem  [FQ_DEPTH];
    logic [BLK_W-1:0]   blk_mem [FQ_DEPTH];

    logic fetch_ok;
    logic advance;
    logic enq;
    logic deq;
    logic bypass;

    assign imem_pc_addr = pc_q;
    assign fq_count     = count_q;

    // Next-state, queue control and decode-side outputs.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        bypass        = 1'b0;
        dec_valid     = (count_q != '0) && !redirect_valid;
        dec_pc        = pc_mem[head_q];
        dec_instr_blk = blk_mem[head_q];

        fetch_ok = (state_q == S_RUN) && fetch_en && !redirect_valid;

`ifdef FETCH_BYPASS_EN
        // Empty queue: hand the block being fetched straight to decode.
        if (fetch_ok && (count_q == '0)) begin
            bypass        = 1'b1;
            dec_valid     = 1'b1;
            dec_pc        = pc_q;
            dec_instr_blk = imem_instr_blk;
        end
`endif

        deq     = dec_valid && dec_ready && !bypass;
        // A pop in the same cycle frees a slot, so a full queue still fetches.
        advance = fetch_ok && ((count_q < CNT_W'(FQ_DEPTH)) || deq);
        // A bypassed block that decode accepts never enters the queue.
        enq     = advance && !(bypass && dec_ready);

        if (advance) begin
            pc_d = pc_q + 32'(PC_INC);
        end
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (deq) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

        if (redirect_valid) begin
            // fetch_ok and dec_valid are already low, so nothing moves.
            pc_d    = {redirect_pc[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = (state_q == S_IDLE) ? S_IDLE : S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE:  state_d = fetch_en ? S_RUN : S_IDLE;
                S_RUN:   state_d = fetch_en ? S_RUN : S_IDLE;
                S_FLUSH: state_d = fetch_en ? S_RUN : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue payload write.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_q]  <= pc_q;
            blk_mem[tail_q] <= imem_instr_blk;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: self-checking bench for fetch_controller.
// A queue-of-PCs reference model predicts occupancy, fetch address and the
// head block each cycle; the instruction memory is a pure function of address.
module tb_fetch_controller;

    localparam int unsigned CW    = 2;
    localparam int unsigned D     = 4;
    localparam int unsigned CNT_W = $clog2(D) + 1;
    localparam int unsigned BLK_W = CW * 32;
    localparam logic [31:0] RPC   = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID = 1;
`else
    localparam int FIRST_VALID = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             fetch_en;
    logic [31:0]      imem_pc_addr;
    logic [BLK_W-1:0] imem_instr_blk;
    logic             dec_valid;
    logic             dec_ready;
    logic [BLK_W-1:0] dec_instr_blk;
    logic [31:0]      dec_pc;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] fq_count;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0]      mq[$];
    logic [31:0]      mpc;
    int               mode;          // 0 idle, 1 run, 2 flush
    // Predictions for the current cycle and the inputs that produced them.
    logic             e_valid;
    logic             e_byp;
    logic [31:0]      e_pc;
    logic [31:0]      e_addr;
    logic [CNT_W-1:0] e_cnt;
    logic             c_fe, c_rdy, c_rv;
    logic [31:0]      c_rpc;

    fetch_controller #(
        .CORE_WIDTH(CW),
        .FQ_DEPTH  (D),
        .RESET_PC  (RPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_pc_addr  (imem_pc_addr),
        .imem_instr_blk(imem_instr_blk),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr_blk (dec_instr_blk),
        .dec_pc        (dec_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fq_count      (fq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [BLK_W-1:0] blk_of(input logic [31:0] pc);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < int'(CW); i++) begin
            b[i*32 +: 32] = (pc + 32'(4 * i)) ^ 32'hC0DE_5A00;
        end
        return b;
    endfunction

    assign imem_instr_blk = blk_of(imem_pc_addr);

    task automatic reset_model();
        mq.delete();
        mpc  = RPC;
        mode = 0;
    endtask

    task automatic do_reset();
        fetch_en       = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rst            = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
    endtask

    // Drive one cycle's inputs and form the model's predictions.
    task automatic apply(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        fetch_en       = fe;
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        c_fe = fe; c_rdy = rdy; c_rv = rv; c_rpc = rpc;
        #1;
        e_addr  = mpc;
        e_cnt   = CNT_W'(mq.size());
        e_valid = (mq.size() != 0) && !rv;
        e_pc    = (mq.size() != 0) ? mq[0] : 32'h0;
        e_byp   = 1'b0;
`ifdef FETCH_BYPASS_EN
        if (mode == 1 && fe && !rv && mq.size() == 0) begin
            e_valid = 1'b1;
            e_pc    = mpc;
            e_byp   = 1'b1;
        end
`endif
    endtask

    // Apply this cycle's effects to the model, then clock.
    task automatic advance();
        int  sz;
        logic deq;
        if (c_rv) begin
            mq.delete();
            mpc = {c_rpc[31:2], 2'b00};
            if (mode != 0) mode = 2;
        end else begin
            sz  = mq.size();
            deq = e_valid && c_rdy && !e_byp;
            if (deq) void'(mq.pop_front());
            if (mode == 1 && c_fe && (sz < int'(D) || deq)) begin
                if (!(e_byp && c_rdy)) mq.push_back(mpc);
                mpc = mpc + 32'(4 * CW);
            end
            mode = c_fe ? 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_en = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #12;
        checks++;
        if ({dec_valid, fq_count, imem_pc_addr} !== {1'b0, CNT_W'(0), RPC}) begin
            errors++;
            $display("FAIL reset: got v=%b cnt=%0d addr=%h, exp v=0 cnt=0 addr=%h",
                     dec_valid, fq_count, imem_pc_addr, RPC);
        end
        do_reset();
    endtask

    task automatic test_stream();
        int first = -1;
        logic [31:0] nxt = RPC;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if ({dec_valid, fq_count, imem_pc_addr} !== {e_valid, e_cnt, e_addr}) begin
                errors++;
                $display("FAIL stream[%0d]: got v=%b cnt=%0d addr=%h, exp v=%b cnt=%0d addr=%h",
                         i, dec_valid, fq_count, imem_pc_addr, e_valid, e_cnt, e_addr);
            end
            if (dec_valid === 1'b1) begin
                if (first < 0) first = i;
                checks++;
                if ({dec_pc, dec_instr_blk} !== {nxt, blk_of(nxt)}) begin
                    errors++;
                    $display("FAIL stream_pc[%0d]: got %h, exp %h", i, dec_pc, nxt);
                end
                nxt = nxt + 32'(4 * CW);
            end
            advance();
        end
        checks++;
        if (first != FIRST_VALID) begin
            errors++;
            $display("FAIL stream_latency: got first valid cycle %0d, exp %0d", first, FIRST_VALID);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] nxt = RPC;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            apply(1'b1, (i >= 11), 1'b0, 32'h0);
            checks++;
            if ({dec_valid, fq_count, imem_pc_addr} !== {e_valid, e_cnt, e_addr}) begin
                errors++;
                $display("FAIL bp[%0d]: got v=%b cnt=%0d addr=%h, exp v=%b cnt=%0d addr=%h",
                         i, dec_valid, fq_count, imem_pc_addr, e_valid, e_cnt, e_addr);
            end
            if (i == 10) begin
                checks++;
                if ({fq_count, imem_pc_addr} !== {CNT_W'(4), 32'h20}) begin
                    errors++;
                    $display("FAIL bp_saturate: got cnt=%0d addr=%h, exp cnt=4 addr=00000020",
                             fq_count, imem_pc_addr);
                end
            end
            // Every accepted block must be the next sequential one.
            if (i >= 11 && dec_valid === 1'b1) begin
                checks++;
                if ({dec_pc, dec_instr_blk} !== {nxt, blk_of(nxt)}) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h, exp %h", i, dec_pc, nxt);
                end
                nxt = nxt + 32'(4 * CW);
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        logic [31:0] seen = 32'hFFFF_FFFF;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        apply(1'b1, 1'b0, 1'b1, 32'h103);
        checks++;
        if ({dec_valid, fq_count} !== {1'b0, CNT_W'(3)}) begin
            errors++;
            $display("FAIL redir_pre: got v=%b cnt=%0d, exp v=0 cnt=3", dec_valid, fq_count);
        end
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if ({dec_valid, fq_count, imem_pc_addr} !== {e_valid, e_cnt, e_addr}) begin
                errors++;
                $display("FAIL redir[%0d]: got v=%b cnt=%0d addr=%h, exp v=%b cnt=%0d addr=%h",
                         i, dec_valid, fq_count, imem_pc_addr, e_valid, e_cnt, e_addr);
            end
            if (i == 0) begin
                checks++;
                if ({dec_valid, fq_count, imem_pc_addr} !== {1'b0, CNT_W'(0), 32'h100}) begin
                    errors++;
                    $display("FAIL redir_flush: got v=%b cnt=%0d addr=%h, exp v=0 cnt=0 addr=00000100",
                             dec_valid, fq_count, imem_pc_addr);
                end
            end
            if (dec_valid === 1'b1 && seen == 32'hFFFF_FFFF) seen = dec_pc;
            advance();
        end
        checks++;
        if (seen !== 32'h100) begin
            errors++;
            $display("FAIL redir_target: got first dec_pc %h, exp 00000100", seen);
        end
    endtask

    task automatic test_full_wrap();
        logic [31:0] nxt = RPC;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        for (int k = 0; k < 12; k++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if ({dec_valid, fq_count, dec_pc, dec_instr_blk} !== {1'b1, CNT_W'(4), nxt, blk_of(nxt)}) begin
                errors++;
                $display("FAIL wrap[%0d]: got v=%b cnt=%0d pc=%h, exp v=1 cnt=4 pc=%h",
                         k, dec_valid, fq_count, dec_pc, nxt);
            end
            nxt = nxt + 32'(4 * CW);
            advance();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({dec_valid, fq_count} !== {1'b1, CNT_W'(2)}) begin
            errors++;
            $display("FAIL midrst_pre: got v=%b cnt=%0d, exp v=1 cnt=2", dec_valid, fq_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({dec_valid, fq_count, imem_pc_addr} !== {1'b0, CNT_W'(0), RPC}) begin
            errors++;
            $display("FAIL midrst: got v=%b cnt=%0d addr=%h, exp v=0 cnt=0 addr=%h",
                     dec_valid, fq_count, imem_pc_addr, RPC);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if ({dec_valid, fq_count, imem_pc_addr} !== {e_valid, e_cnt, e_addr}) begin
                errors++;
                $display("FAIL midrst_after[%0d]: got v=%b cnt=%0d addr=%h, exp v=%b cnt=%0d addr=%h",
                         i, dec_valid, fq_count, imem_pc_addr, e_valid, e_cnt, e_addr);
            end
            advance();
        end
    endtask

    task automatic test_fetch_en_drop();
        logic [31:0] frozen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        frozen = 32'(3 * 4 * CW);
        for (int i = 0; i < 10; i++) begin
            apply((i >= 3), 1'b1, 1'b0, 32'h0);
            checks++;
            if ({dec_valid, fq_count, imem_pc_addr} !== {e_valid, e_cnt, e_addr}) begin
                errors++;
                $display("FAIL fe_drop[%0d]: got v=%b cnt=%0d addr=%h, exp v=%b cnt=%0d addr=%h",
                         i, dec_valid, fq_count, imem_pc_addr, e_valid, e_cnt, e_addr);
            end
            if (i < 4) begin
                checks++;
                if (imem_pc_addr !== frozen) begin
                    errors++;
                    $display("FAIL fe_frozen[%0d]: got addr=%h, exp %h", i, imem_pc_addr, frozen);
                end
            end
            if (e_valid) begin
                checks++;
                if ({dec_pc, dec_instr_blk} !== {e_pc, blk_of(e_pc)}) begin
                    errors++;
                    $display("FAIL fe_drop_pc[%0d]: got %h, exp %h", i, dec_pc, e_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic fe, rdy, rv;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            fe  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 24) == 0);
            apply(fe, rdy, rv, $urandom);
            checks++;
            if ({dec_valid, fq_count, imem_pc_addr} !== {e_valid, e_cnt, e_addr}) begin
                errors++;
                $display("FAIL rand[%0d]: got v=%b cnt=%0d addr=%h, exp v=%b cnt=%0d addr=%h",
                         i, dec_valid, fq_count, imem_pc_addr, e_valid, e_cnt, e_addr);
            end
            if (e_valid) begin
                checks++;
                if ({dec_pc, dec_instr_blk} !== {e_pc, blk_of(e_pc)}) begin
                    errors++;
                    $display("FAIL rand_pc[%0d]: got %h, exp %h", i, dec_pc, e_pc);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_full_wrap();
        test_reset_midstream();
        test_fetch_en_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter CORE_WIDTH, default 2, giving instructions per fetch block.
REQ-002 SHALL have parameter FQ_DEPTH, default 4, giving fetch-queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, giving the first fetch address.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port fetch_en  input  1  global fetch enable.
REQ-007 SHALL have port imem_pc_addr  output  32  address to the combinational instruction memory.
REQ-008 SHALL have port imem_instr_blk  input  CORE_WIDTH*32  block returned for imem_pc_addr in the same cycle.
REQ-009 SHALL have port dec_valid  output  1  head block valid toward decode.
REQ-010 SHALL have port dec_ready  input  1  decode accepts head block.
REQ-011 SHALL have port dec_instr_blk  output  CORE_WIDTH*32  head block instructions.
REQ-012 SHALL have port dec_pc  output  32  PC of instruction 0 of the head block.
REQ-013 SHALL have port redirect_valid  input  1  branch/exception redirect request.
REQ-014 SHALL have port redirect_pc  input  32  redirect target.
REQ-015 SHALL have port fq_count  output  $clog2(FQ_DEPTH)+1  current queue occupancy.

Function
REQ-016 SHALL hold a PC register; imem_pc_addr = PC combinationally.
REQ-017 SHALL implement states IDLE, RUN, FLUSH.
REQ-018 SHALL transition IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; FLUSH->RUN if fetch_en=1 else IDLE, after exactly one cycle.
REQ-019 SHALL enqueue {PC, imem_instr_blk} and advance PC by 4*CORE_WIDTH (mod 2^32) when state=RUN, fetch_en=1, redirect_valid=0, and (fq_count<FQ_DEPTH or a dequeue occurs this cycle).
REQ-020 SHALL dequeue when dec_valid && dec_ready; dec_valid = (fq_count!=0) && !redirect_valid.
REQ-021 SHALL drive dec_instr_blk/dec_pc from the head entry; their values are don't-care when dec_valid=0.
REQ-022 SHALL support simultaneous enqueue and dequeue at full and at non-empty occupancy, with fq_count unchanged.
REQ-023 SHALL wrap head/tail pointers modulo FQ_DEPTH.
REQ-024 SHALL, on redirect_valid=1 in any state, clear the queue (fq_count=0 next cycle), load PC with {redirect_pc[31:2],2'b00}, and enter FLUSH (from IDLE: stay IDLE); no enqueue or dequeue in that cycle.
REQ-025 SHALL NOT enqueue in FLUSH; first fetch at the redirect target occurs in the following RUN cycle.
REQ-026 SHALL give a latency of one cycle from fetch at PC to dec_valid with that block (no bypass build).

Reset
REQ-027 SHALL on rst=1 asynchronously set PC=RESET_PC, state=IDLE, fq_count=0, pointers=0, dec_valid=0.
REQ-028 SHALL discard all queued blocks when rst asserts mid-operation; queue payload storage need not be reset.

Configuration
REQ-029 SHALL recognise macro FETCH_BYPASS_EN.
REQ-030 SHALL, with FETCH_BYPASS_EN defined, when state=RUN, fetch_en=1, fq_count=0, redirect_valid=0: drive dec_valid=1, dec_instr_blk=imem_instr_blk, dec_pc=PC the same cycle; if dec_ready=1 the block is consumed without enqueue and PC advances, else it is enqueued normally.
REQ-031 SHALL, without FETCH_BYPASS_EN, never present imem data to decode in the cycle it is fetched.

Verification
REQ-032 SHALL cover reset then fetch_en=1, dec_ready=1, CORE_WIDTH=2 -> dec_pc sequence 0x0,0x8,0x10,... one per cycle from cycle 2 (cycle 1 with bypass).
REQ-033 SHALL cover dec_ready=0 for 10 cycles -> fq_count saturates at 4, PC holds at 0x20, no block lost or duplicated after dec_ready=1.
REQ-034 SHALL cover redirect_valid=1, redirect_pc=0x103 with fq_count=3 -> fq_count=0 next cycle, one FLUSH cycle, next dec_pc=0x100.
REQ-035 SHALL cover full queue with dec_ready=1 continuously -> enqueue and dequeue every cycle, fq_count stays 4, pointers wrap correctly over 12 blocks.
REQ-036 SHALL cover rst asserted mid-stream with fq_count=2 -> dec_valid=0 immediately, PC=RESET_PC, state IDLE.
REQ-037 SHALL cover fetch_en dropped for 3 cycles in RUN -> no enqueue, PC frozen, queue drains; fetch resumes at frozen PC.
